// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from vga_timing_gen to the pixel renderer and DVI output wrapper.
// Every signal is registered in the sys_clk domain and describes the same pixel.
interface vga_timing_gen_if;
    logic        pix_ce;
    logic        h_sync;
    logic        v_sync;
    logic        h_enable;
    logic        v_enable;
    logic        video_active;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        line_start;
    logic        frame_start;

    modport master (
        output pix_ce, h_sync, v_sync, h_enable, v_enable, video_active,
               pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        input  pix_ce, h_sync, v_sync, h_enable, v_enable, video_active,
               pix_x, pix_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel clock enable from sys_clk, pixel position counters
// and zero-skew registered sync/enable/start decodes of the current position.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV out of range 2..16");
    end
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit range");
    end

    logic [3:0]  div_cnt_q, div_cnt_d;
    logic        pix_ce_q, pix_ce_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic        h_enable_q, h_enable_d;
    logic        v_enable_q, v_enable_d;
    logic        video_active_q, video_active_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
        pix_ce_d  = (div_cnt_d == DIV_LAST);

        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        if (pix_ce_q) begin
            if (pix_x_q == H_LAST) begin
                pix_x_d = 11'd0;
                pix_y_d = (pix_y_q == V_LAST) ? 11'd0 : pix_y_q + 11'd1;
            end else begin
                pix_x_d = pix_x_q + 11'd1;
            end
        end

        // Decode the next position so outputs land on the same edge as pix_x/pix_y.
        h_enable_d     = (pix_x_d < H_ACT);
        v_enable_d     = (pix_y_d < V_ACT);
        video_active_d = h_enable_d & v_enable_d;
        h_sync_d       = (pix_x_d >= HS_BEG && pix_x_d < HS_END) ? H_POL : ~H_POL;
        v_sync_d       = (pix_y_d >= VS_BEG && pix_y_d < VS_END) ? V_POL : ~V_POL;
        line_start_d   = pix_ce_q && (pix_x_d == 11'd0);
        frame_start_d  = line_start_d && (pix_y_d == 11'd0);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_q      <= 4'd0;
            pix_ce_q       <= 1'b0;
            pix_x_q        <= 11'd0;
            pix_y_q        <= 11'd0;
            h_sync_q       <= ~H_POL;
            v_sync_q       <= ~V_POL;
            h_enable_q     <= 1'b1;
            v_enable_q     <= 1'b1;
            video_active_q <= 1'b1;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pix_ce_q       <= pix_ce_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            h_sync_q       <= h_sync_d;
            v_sync_q       <= v_sync_d;
            h_enable_q     <= h_enable_d;
            v_enable_q     <= v_enable_d;
            video_active_q <= video_active_d;
            line_start_q   <= line_start_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign vid.pix_ce       = pix_ce_q;
    assign vid.h_sync       = h_sync_q;
    assign vid.v_sync       = v_sync_q;
    assign vid.h_enable     = h_enable_q;
    assign vid.v_enable     = v_enable_q;
    assign vid.video_active = video_active_q;
    assign vid.pix_x        = pix_x_q;
    assign vid.pix_y        = pix_y_q;
    assign vid.line_start   = line_start_q;
    assign vid.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets with random resets, compared every
// cycle against a model that derives the raster from the cycle count since reset.
module tb_vga_timing_gen;

    logic sys_clk;
    logic rst_a, rst_b, rst_c;
    int   n_tests, n_fail;

    vga_timing_gen_if if_a();
    vga_timing_gen_if if_b();
    vga_timing_gen_if if_c();

    // Defaults: 640x480, CLK_DIV 4.
    vga_timing_gen u_dut_a (
        .sys_clk (sys_clk),
        .sys_rst (rst_a),
        .vid     (if_a)
    );

    // Small raster: 12-pixel lines, 7-line frames, CLK_DIV 2.
    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_b (
        .sys_clk (sys_clk),
        .sys_rst (rst_b),
        .vid     (if_b)
    );

    // Zero-length porches, positive sync polarity, CLK_DIV 3.
    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(0),
        .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(0),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_dut_c (
        .sys_clk (sys_clk),
        .sys_rst (rst_c),
        .vid     (if_c)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [29:0] obs_a, obs_b, obs_c;
    assign obs_a = {if_a.pix_ce, if_a.h_sync, if_a.v_sync, if_a.h_enable, if_a.v_enable,
                    if_a.video_active, if_a.line_start, if_a.frame_start, if_a.pix_x, if_a.pix_y};
    assign obs_b = {if_b.pix_ce, if_b.h_sync, if_b.v_sync, if_b.h_enable, if_b.v_enable,
                    if_b.video_active, if_b.line_start, if_b.frame_start, if_b.pix_x, if_b.pix_y};
    assign obs_c = {if_c.pix_ce, if_c.h_sync, if_c.v_sync, if_c.h_enable, if_c.v_enable,
                    if_c.video_active, if_c.line_start, if_c.frame_start, if_c.pix_x, if_c.pix_y};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected outputs after k sys_clk edges since reset release (k=0 is the reset state).
    function automatic logic [29:0] ref_out(input int d, input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf, input int vs,
                                            input int vb, input bit hp, input bit vp,
                                            input longint k);
        longint n, ht, vt, x, y;
        bit ce, first, ls, fs, hsy, vsy, he, ve;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        n     = k / d;
        x     = n % ht;
        y     = (n / ht) % vt;
        ce    = (k % d) == (d - 1);
        first = (k > 0) && (k % d == 0);
        ls    = first && (x == 0);
        fs    = ls && (y == 0);
        hsy   = (x >= ha + hf && x < ha + hf + hs) ? hp : !hp;
        vsy   = (y >= va + vf && y < va + vf + vs) ? vp : !vp;
        he    = x < ha;
        ve    = y < va;
        return {ce, hsy, vsy, he, ve, he & ve, ls, fs, 11'(x), 11'(y)};
    endfunction

    function automatic logic [29:0] exp_a(input longint k);
        return ref_out(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, k);
    endfunction
    function automatic logic [29:0] exp_b(input longint k);
        return ref_out(2, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, k);
    endfunction
    function automatic logic [29:0] exp_c(input longint k);
        return ref_out(3, 4, 0, 2, 0, 2, 0, 1, 0, 1'b1, 1'b1, k);
    endfunction

    longint k_a, k_b, k_c;
    longint last_ls_a, last_fs_b;
    int     hs_low_a, act_b, vs_low_b;

    task automatic clear_a();
        k_a = 0; last_ls_a = -1; hs_low_a = 0;
    endtask
    task automatic clear_b();
        k_b = 0; last_fs_b = -1; act_b = 0; vs_low_b = 0;
    endtask

    task automatic check_all();
        chk("a_outputs", {2'b0, obs_a}, {2'b0, exp_a(k_a)});
        chk("b_outputs", {2'b0, obs_b}, {2'b0, exp_b(k_b)});
        chk("c_outputs", {2'b0, obs_c}, {2'b0, exp_c(k_c)});
        if (if_a.line_start) begin
            if (last_ls_a >= 0) begin
                chk("a_line_period", 32'(k_a - last_ls_a), 32'd3200);
                chk("a_hsync_low_cycles", 32'(hs_low_a), 32'd384);
            end
            last_ls_a = k_a;
            hs_low_a  = 0;
        end
        if (!if_a.h_sync) hs_low_a++;
        if (if_b.frame_start) begin
            if (last_fs_b >= 0) begin
                chk("b_frame_period", 32'(k_b - last_fs_b), 32'd168);
                chk("b_active_cycles", 32'(act_b), 32'd64);
                chk("b_vsync_low_cycles", 32'(vs_low_b), 32'd24);
            end
            last_fs_b = k_b;
            act_b     = 0;
            vs_low_b  = 0;
        end
        if (if_b.video_active) act_b++;
        if (!if_b.v_sync) vs_low_b++;
    endtask

    // Reset is asserted between edges; outputs must change without waiting for a clock.
    task automatic pulse_a();
        rst_a = 1'b1;
        #1;
        clear_a();
        chk("a_reset_state", {2'b0, obs_a}, {2'b0, 8'b0_1_1_1_1_1_0_0, 22'd0});
        #1 rst_a = 1'b0;
    endtask
    task automatic pulse_b();
        rst_b = 1'b1;
        #1;
        clear_b();
        chk("b_reset_state", {2'b0, obs_b}, {2'b0, exp_b(0)});
        #1 rst_b = 1'b0;
    endtask
    task automatic pulse_c();
        rst_c = 1'b1;
        #1;
        k_c = 0;
        chk("c_reset_state", {2'b0, obs_c}, {2'b0, 8'b0_0_0_1_1_1_0_0, 22'd0});
        #1 rst_c = 1'b0;
    endtask

    int rst_at;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        clear_a(); clear_b(); k_c = 0;
        repeat (2) @(negedge sys_clk);
        #1;
        check_all();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        rst_at = 1000 + $urandom_range(0, 400);
        for (int cyc = 0; cyc < 14000; cyc++) begin
            @(posedge sys_clk);
            k_a++; k_b++; k_c++;
            @(negedge sys_clk);
            check_all();
            if (cyc == rst_at) pulse_a();
            if ($urandom_range(0, 499) == 0) pulse_b();
            if ($urandom_range(0, 299) == 0) pulse_c();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the display path. Driven from `sys_clk`, it derives a pixel-rate clock enable and produces registered horizontal/vertical sync, per-axis active-video enables, combined data-enable and pixel coordinates. These feed the pixel renderer and the CH7301 DVI output wrapper. Defaults give 640x480@60 from a 100 MHz `sys_clk` (25 MHz pixel rate).

## Interface
- `CLK_DIV`, 4: `sys_clk` cycles per pixel. Legal range is 2..16.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal segment lengths in pixels. `H_TOTAL` = sum = 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical segment lengths in lines. `V_TOTAL` = sum = 525.
- `H_POL`, 0; `V_POL`, 0: sync asserted level. 0 means active-low.
- `sys_clk` in 1: the single clock.
- `sys_rst` in 1: asynchronous, active-high reset.
- `pix_ce` out 1: one-cycle pulse marking the last `sys_clk` cycle of each pixel.
- `h_sync` out 1: horizontal sync at level `H_POL` while asserted.
- `v_sync` out 1: vertical sync at level `V_POL` while asserted.
- `h_enable` out 1: `pix_x` < `H_ACTIVE`.
- `v_enable` out 1: `pix_y` < `V_ACTIVE`.
- `video_active` out 1: `h_enable` & `v_enable`.
- `pix_x` out 11: horizontal counter, 0..`H_TOTAL`-1.
- `pix_y` out 11: vertical counter, 0..`V_TOTAL`-1.
- `line_start` out 1: one-cycle pulse in the first `sys_clk` cycle of a pixel with `pix_x`=0.
- `frame_start` out 1: one-cycle pulse in the first `sys_clk` cycle of pixel (0,0).

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_DIV`-1 and wraps.
  - `pix_ce` is registered and high exactly while `div_cnt`=`CLK_DIV`-1.
- **Position advance.** The position advances only on a rising edge that ends a cycle with `pix_ce`=1.
  - Normal case: `pix_x`+1.
  - At `pix_x`=`H_TOTAL`-1: `pix_x`=0 and `pix_y`+1.
  - At `pix_x`=`H_TOTAL`-1 and `pix_y`=`V_TOTAL`-1: both wrap to 0.
- **Registered decodes.** All decodes are registered from the next position. Every output therefore describes the current (`pix_x`,`pix_y`) in the same cycle, with zero skew between outputs.
  - `h_sync` = `H_POL` iff `H_ACTIVE`+`H_FP` <= `pix_x` < `H_ACTIVE`+`H_FP`+`H_SYNC`; otherwise ~`H_POL`.
  - `v_sync` = `V_POL` iff `V_ACTIVE`+`V_FP` <= `pix_y` < `V_ACTIVE`+`V_FP`+`V_SYNC`; otherwise ~`V_POL`.
  - `v_sync` changes only when `pix_x` wraps to 0, i.e. it is line-aligned.
  - `line_start` and `frame_start` are set on the advancing edge when the new position qualifies, and cleared on the next edge.
- **Arithmetic.** Comparisons use unsigned 11-bit arithmetic. Segment sums are elaboration-time constants.
  - `H_TOTAL` and `V_TOTAL` must be <= 2047.
  - A zero-length FP or BP segment is legal.
- **Reset state.** Async reset forces:
  - `div_cnt`=0, `pix_x`=0, `pix_y`=0;
  - `pix_ce`=0, `line_start`=0, `frame_start`=0;
  - `h_enable`=1, `v_enable`=1, `video_active`=1;
  - `h_sync`=~`H_POL`, `v_sync`=~`V_POL`.
- **Reset mid-frame.** Assertion takes effect immediately with no completion of the current line. After release the raster restarts at (0,0) without a `frame_start` pulse for that first pixel. The first `frame_start` occurs at the next wrap.

## Timing
- Reset released before edge 1:
  - `pix_ce`=1 in the cycles after edges `CLK_DIV`-1, 2*`CLK_DIV`-1, ...
  - Position advances on edges `CLK_DIV`, 2*`CLK_DIV`, ...
- Each pixel lasts exactly `CLK_DIV` cycles.
- Line = `H_TOTAL`*`CLK_DIV` cycles. With defaults: 3200.
- Frame = `V_TOTAL`*`H_TOTAL`*`CLK_DIV` cycles. With defaults: 1,680,000.
- Latency from position change to all decoded outputs: 0 cycles relative to `pix_x`/`pix_y`, since all are updated on the same edge.
- `line_start` is high for 1 `sys_clk` cycle, not `CLK_DIV` cycles. It coincides with `frame_start` at (0,0).

## Test plan
- **Reset values.** Assert `sys_rst` mid-line at (300,200) -> outputs immediately match the reset state listed above. `frame_start` stays 0 until 1,680,000 cycles after release (defaults).
- **Pixel enable cadence.** Defaults -> `pix_ce` high every 4th cycle, exactly one cycle wide. `pix_x` steps 0,1,2,... every 4 cycles. No `pix_x` change occurs without a preceding `pix_ce`.
- **Horizontal timing.**
  - `h_sync` is low for `pix_x` 656..751 only, i.e. exactly 384 cycles per line.
  - `h_enable` is high for `pix_x` 0..639.
  - `line_start` pulses every 3200 cycles.
- **Vertical timing.**
  - `v_sync` is low for `pix_y` 490..491 only: 6400 cycles, starting on the edge where `pix_x` becomes 0.
  - `v_enable` is high for lines 0..479.
  - `video_active` counts exactly 307,200 pixels per frame.
- **Wrap-around.** Position (799,524) -> next advance gives (0,0). `frame_start` and `line_start` both pulse for one cycle.
- **Parameter variant.** `CLK_DIV`=2 with H 8/1/2/1 and V 4/1/1/1 -> 12-pixel lines and 7-line frames. `frame_start` period is 168 cycles; sync windows are at `pix_x` 9..10 and `pix_y` 5.
